// File: rtl/hc_add_stream_ctrl.sv
//------------------------------------------------------------------------------
// Module   : hc_add_stream_ctrl
// Brief    : Issue/collect controller for a fixed-latency pipelined adder with
//            credit-based flow control and an output result FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hc_add_stream_ctrl #(
  parameter int WIDTH = 16,
  parameter int LAT   = 7,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [LAT:0]    r_vld;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_outstanding;
  logic [WIDTH:0]  r_mem [DEPTH];

  logic            w_accept;
  logic            w_pop;
  logic            w_empty;
  logic [WIDTH:0]  w_head;

  // Credits cover both in-flight tags and FIFO occupancy, so the FIFO can never overflow.
  assign in_ready  = !rst && (r_outstanding < CW'(DEPTH));
  assign w_accept  = in_valid & in_ready;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign out_valid = !w_empty;
  assign w_pop     = out_valid & out_ready;
  assign busy      = (r_outstanding != '0);

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign out_sum   = w_empty ? '0 : w_head[WIDTH-1:0];
  assign out_cout  = !w_empty & w_head[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (w_accept) begin
      add_a   <= in_a;
      add_b   <= in_b;
      add_cin <= in_cin;
    end
  end

  // r_vld[LAT] lines up with the adder's output register holding the tagged result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[LAT-1:0], w_accept};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (r_vld[LAT]) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (r_vld[LAT]) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {add_cout, add_sum};
    end
  end

endmodule

`default_nettype wire
